alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the combinational 8-bit ALU.
- Adds width generalisation, variable-distance shifts executed one bit per cycle, a shift-add multiplier, registered result/flags and a start/busy/done handshake.
- Sits between the accumulator/register file and the control FSM. The control unit pulses start and waits for done.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of two ≥4.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- opcode  input  4  operation select; latched on accept
- a  input  WIDTH  operand A; latched on accept
- b  input  WIDTH  operand B / shift amount; latched on accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; y/flags valid from this cycle
- y  output  WIDTH  registered result, held until next done
- zero  output  1  registered: y==0
- carry  output  1  registered carry/borrow/shift-out/overflow (see Behaviour)

Behaviour:
- Reset: all outputs are 0 (busy, done, y, zero, carry), FSM=IDLE, counter=0.
  - Reset is asynchronous and takes effect mid-operation.
  - The in-flight op is discarded and no done is issued.
- FSM states: IDLE, EXEC.
- IDLE:
  - If start=1 at an edge: latch opcode/a/b, load cycle counter n-1, busy<=1, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - Each edge performs one step and decrements the counter.
  - On the edge where the counter is 0: write y/zero/carry, done<=1, busy<=0, go to IDLE.
- done is high for exactly one cycle, during which the FSM is already in IDLE.
  - A start in that same cycle is accepted (back-to-back ops, no bubble).
- start while busy=1 is ignored. No queueing. Latched operands are unaffected by input changes after accept.
- Latency, counted from the accept edge k, is n cycles (done high after edge k+n):
  - 0000 ADD: n=1, y=a+b, carry=carry-out.
  - 0001 SUB: n=1, y=a-b, carry=borrow (a<b unsigned).
  - 0010 AND, 0011 OR, 0100 XOR: n=1, carry=0.
  - 0101 SHL: n=max(1,s), where s=b[SHW-1:0]. y=a<<s, one bit per EXEC cycle. carry=last bit shifted out; 0 if s=0.
  - 0110 SHR: as SHL, logical right shift; carry=last bit shifted out.
  - 0111 MUL: n=WIDTH, shift-add over the latched b bits, LSB first. y=low WIDTH bits of a*b. carry=1 iff the high WIDTH bits are nonzero.
  - 1000 ROL, 1001 ROR: n=1, rotate by 1, carry=the bit rotated across.
  - 1010 DEC: n=1, y=a-1, carry=1 iff a==0 (y wraps to all ones).
  - 1011 INV: n=1, y=~a, carry=0.
  - 1100-1111 (CLR/undefined): n=1, y=0, zero=1, carry=0.
- zero is computed from the final y for every opcode.
- All arithmetic is modulo 2^WIDTH. The intermediate product register is 2*WIDTH bits.
- y/zero/carry change only on a done edge or reset. They are never visible in a partially shifted or partially multiplied state.

Test Plan:
- Reset mid-MUL: WIDTH=8, MUL a=0x0F b=0x11, assert rst at cycle 3 → busy=0, done never pulses, y=0. Then ADD 0x01+0x02 → done 1 cycle after accept, y=0x03.
- ADD/SUB flags: ADD 0xFF+0x01 → y=0x00, zero=1, carry=1. SUB 0x03-0x05 → y=0xFE, carry=1, zero=0.
- Variable shifts: SHL a=0x81 s=7 → done exactly 7 cycles after accept, y=0x80, carry=0. SHR a=0x81 s=0 → n=1, y=0x81, carry=0. SHL a=0xC0 s=2 → y=0x00, carry=1, zero=1.
- Multiplier: MUL 0x0F*0x11 → done 8 cycles after accept, y=0xFF, carry=0. MUL 0x10*0x10 → y=0x00, carry=1, zero=1.
- Handshake: start held high during an 8-cycle MUL → ignored while busy. New ADD accepted in the done cycle; its done arrives on the following cycle and the MUL result is held until then. Change a/b after accept → result unchanged.
- Misc: DEC 0x00 → y=0xFF, carry=1. ROL 0x80 → y=0x01, carry=1. Opcode 0xE → y=0, zero=1. Repeat the ADD and MUL cases with WIDTH=16 (MUL latency 16).

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle parametrised ALU with start/busy/done handshake
// Shifts run one bit per cycle and MUL is shift-add; y/zero/carry update only on done.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry
);

  typedef enum logic {IDLE, EXEC} state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_SHL = 4'h5, OP_SHR = 4'h6, OP_MUL = 4'h7,
                         OP_ROL = 4'h8, OP_ROR = 4'h9, OP_DEC = 4'hA, OP_INV = 4'hB;

  state_t               state_q;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     wa_q, wa_d, wb_q, wb_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, mc_q, mc_d;
  logic                 sc_q, sc_d, shen_q;
  logic [SHW-1:0]       cnt_q, cnt_init;
  logic                 busy_q, done_q, zero_q, carry_q;
  logic [WIDTH-1:0]     y_q;
  logic [SHW-1:0]       amt;
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     res_y;
  logic                 res_c;

  assign busy  = busy_q;
  assign done  = done_q;
  assign y     = y_q;
  assign zero  = zero_q;
  assign carry = carry_q;

  assign amt = b[SHW-1:0];

  // Counter holds remaining steps minus one; a zero-distance shift still takes one cycle.
  always_comb begin
    cnt_init = '0;
    if ((opcode == OP_SHL || opcode == OP_SHR) && amt != '0)
      cnt_init = amt - SHW'(1);
    else if (opcode == OP_MUL)
      cnt_init = SHW'(WIDTH - 1);
  end

  always_comb begin
    wa_d   = wa_q;
    wb_d   = wb_q;
    sc_d   = sc_q;
    prod_d = prod_q;
    mc_d   = mc_q;
    case (op_q)
      OP_SHL: if (shen_q) begin
        wa_d = wa_q << 1;
        sc_d = wa_q[WIDTH-1];
      end
      OP_SHR: if (shen_q) begin
        wa_d = wa_q >> 1;
        sc_d = wa_q[0];
      end
      OP_MUL: begin
        if (wb_q[0]) prod_d = prod_q + mc_q;
        mc_d = mc_q << 1;
        wb_d = wb_q >> 1;
      end
      default: ;
    endcase
  end

  assign sum  = {1'b0, wa_q} + {1'b0, wb_q};
  assign diff = {1'b0, wa_q} - {1'b0, wb_q};

  always_comb begin
    res_y = '0;
    res_c = 1'b0;
    case (op_q)
      OP_ADD: begin res_y = sum[WIDTH-1:0];  res_c = sum[WIDTH];  end
      OP_SUB: begin res_y = diff[WIDTH-1:0]; res_c = diff[WIDTH]; end
      OP_AND: res_y = wa_q & wb_q;
      OP_OR:  res_y = wa_q | wb_q;
      OP_XOR: res_y = wa_q ^ wb_q;
      OP_SHL, OP_SHR: begin res_y = wa_d; res_c = sc_d; end
      OP_MUL: begin res_y = prod_d[WIDTH-1:0]; res_c = |prod_d[2*WIDTH-1:WIDTH]; end
      OP_ROL: begin res_y = {wa_q[WIDTH-2:0], wa_q[WIDTH-1]}; res_c = wa_q[WIDTH-1]; end
      OP_ROR: begin res_y = {wa_q[0], wa_q[WIDTH-1:1]};       res_c = wa_q[0];       end
      OP_DEC: begin res_y = wa_q - WIDTH'(1); res_c = (wa_q == '0); end
      OP_INV: res_y = ~wa_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      prod_q  <= '0;
      mc_q    <= '0;
      sc_q    <= 1'b0;
      shen_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          op_q    <= opcode;
          wa_q    <= a;
          wb_q    <= b;
          mc_q    <= {{WIDTH{1'b0}}, a};
          prod_q  <= '0;
          sc_q    <= 1'b0;
          shen_q  <= (amt != '0);
          cnt_q   <= cnt_init;
          busy_q  <= 1'b1;
          state_q <= EXEC;
        end
        EXEC: begin
          wa_q   <= wa_d;
          wb_q   <= wb_d;
          sc_q   <= sc_d;
          prod_q <= prod_d;
          mc_q   <= mc_d;
          if (cnt_q == '0) begin
            y_q     <= res_y;
            zero_q  <= (res_y == '0);
            carry_q <= res_c;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - SHW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [3:0]  op8 = '0, op16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy8, done8, zero8, carry8;
  logic        busy16, done16, zero16, carry16;
  logic [7:0]  y8;
  logic [15:0] y16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .opcode(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8), .zero(zero8), .carry(carry8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .opcode(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .y(y16), .zero(zero16), .carry(carry16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain arithmetic on wide integers.
  function automatic void model(input int w, input int op, input longint unsigned a,
                                input longint unsigned b, output longint unsigned ry,
                                output longint unsigned rc, output int n);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned t;
    int s = int'(b % longint'(w));
    ry = 0; rc = 0; n = 1;
    case (op)
      0: begin t = a + b; ry = t & mask; rc = (t >> w) & 1; end
      1: begin ry = (a - b) & mask; rc = (a < b) ? 1 : 0; end
      2: ry = a & b;
      3: ry = a | b;
      4: ry = a ^ b;
      5: begin
        ry = (a << s) & mask; rc = (s == 0) ? 0 : (a >> (w - s)) & 1; n = (s == 0) ? 1 : s;
      end
      6: begin
        ry = a >> s; rc = (s == 0) ? 0 : (a >> (s - 1)) & 1; n = (s == 0) ? 1 : s;
      end
      7: begin t = a * b; ry = t & mask; rc = ((t >> w) != 0) ? 1 : 0; n = w; end
      8: begin ry = ((a << 1) | (a >> (w - 1))) & mask; rc = (a >> (w - 1)) & 1; end
      9: begin ry = (a >> 1) | ((a & 1) << (w - 1)); rc = a & 1; end
      10: begin ry = (a - 1) & mask; rc = (a == 0) ? 1 : 0; end
      11: ry = ~a & mask;
      default: ;
    endcase
  endfunction

  task automatic set_in(input int w, input logic st, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b);
    if (w == 8) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = st; op16 = op; a16 = a; b16 = b;
    end
  endtask

  task automatic rd(input int w, output logic od, output logic ob, output logic [15:0] oy,
                    output logic oz, output logic oc);
    if (w == 8) begin
      od = done8; ob = busy8; oy = {8'h00, y8}; oz = zero8; oc = carry8;
    end else begin
      od = done16; ob = busy16; oy = y16; oz = zero16; oc = carry16;
    end
  endtask

  // Issue one op, scramble inputs after accept, then check latency and results.
  task automatic run_op(input string tag, input int w, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ey, input logic ec, input int en);
    logic od, ob, oz, oc;
    logic [15:0] oy;
    int lat = 0;
    bit got = 0;
    @(negedge clk);
    set_in(w, 1'b1, op, a, b);
    @(posedge clk);
    #1;
    set_in(w, 1'b0, 4'(op ^ 4'h3), 16'($urandom), 16'($urandom));
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      rd(w, od, ob, oy, oz, oc);
      if (od) got = 1;
    end
    check({tag, " latency"}, 64'(lat), 64'(en));
    check({tag, " y"}, 64'(oy), 64'(ey));
    check({tag, " zero"}, 64'(oz), 64'(ey == 16'h0));
    check({tag, " carry"}, 64'(oc), 64'(ec));
    check({tag, " busy"}, 64'(ob), 64'(0));
  endtask

  task automatic run_rand(input int w, input int cnt);
    longint unsigned ry, rc;
    int n;
    logic [15:0] a, b;
    logic [3:0] op;
    for (int i = 0; i < cnt; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (w == 8) begin a[15:8] = 8'h00; b[15:8] = 8'h00; end
      model(w, int'(op), longint'(a), longint'(b), ry, rc, n);
      run_op($sformatf("rand w%0d op%0h", w, op), w, op, a, b, 16'(ry), rc[0], n);
    end
  endtask

  initial begin
    logic saw_done;
    int lat;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy8), 64'(0));
    check("reset done", 64'(done8), 64'(0));
    check("reset y", 64'(y8), 64'(0));
    check("reset zero", 64'(zero8), 64'(0));
    check("reset carry", 64'(carry8), 64'(0));
    check("reset y16", 64'(y16), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("add ff+01", 8, 4'h0, 16'hFF, 16'h01, 16'h00, 1'b1, 1);
    run_op("sub 03-05", 8, 4'h1, 16'h03, 16'h05, 16'hFE, 1'b1, 1);
    run_op("shl 81<<7", 8, 4'h5, 16'h81, 16'h07, 16'h80, 1'b0, 7);
    run_op("shr 81>>0", 8, 4'h6, 16'h81, 16'h00, 16'h81, 1'b0, 1);
    run_op("shl c0<<2", 8, 4'h5, 16'hC0, 16'h02, 16'h00, 1'b1, 2);
    run_op("mul 0f*11", 8, 4'h7, 16'h0F, 16'h11, 16'hFF, 1'b0, 8);
    run_op("mul 10*10", 8, 4'h7, 16'h10, 16'h10, 16'h00, 1'b1, 8);
    run_op("dec 00", 8, 4'hA, 16'h00, 16'h00, 16'hFF, 1'b1, 1);
    run_op("rol 80", 8, 4'h8, 16'h80, 16'h00, 16'h01, 1'b1, 1);
    run_op("op e", 8, 4'hE, 16'h5A, 16'h33, 16'h00, 1'b0, 1);
    run_op("ror 01", 8, 4'h9, 16'h01, 16'h00, 16'h80, 1'b1, 1);

    // Start held through a MUL, with an ADD presented; ADD lands in the done cycle.
    @(negedge clk);
    set_in(8, 1'b1, 4'h7, 16'h0F, 16'h11);
    @(posedge clk);
    #1;
    set_in(8, 1'b1, 4'h0, 16'h01, 16'h02);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hs mul latency", 64'(lat), 64'(8));
    check("hs mul y", 64'(y8), 64'hFF);
    @(posedge clk);
    #1;
    set_in(8, 1'b0, 4'h0, 16'h00, 16'h00);
    check("hs add accepted busy", 64'(busy8), 64'(1));
    check("hs mul y held", 64'(y8), 64'hFF);
    check("hs no done between", 64'(done8), 64'(0));
    @(posedge clk);
    #1;
    check("hs add done", 64'(done8), 64'(1));
    check("hs add y", 64'(y8), 64'h03);

    // Reset asserted mid-MUL discards the op.
    @(negedge clk);
    set_in(8, 1'b1, 4'h7, 16'h0F, 16'h11);
    @(posedge clk);
    #1;
    set_in(8, 1'b0, 4'h0, 16'h00, 16'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst mid busy", 64'(busy8), 64'(0));
    check("rst mid y", 64'(y8), 64'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      if (done8) saw_done = 1'b1;
    end
    check("rst mid no done", 64'(saw_done), 64'(0));
    run_op("add after rst", 8, 4'h0, 16'h01, 16'h02, 16'h03, 1'b0, 1);

    run_op("w16 add", 16, 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1);
    run_op("w16 mul", 16, 4'h7, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 16);
    run_op("w16 mul ovf", 16, 4'h7, 16'h0100, 16'h0100, 16'h0000, 1'b1, 16);
    run_op("w16 shr", 16, 4'h6, 16'h8001, 16'h000F, 16'h0001, 1'b0, 15);

    run_rand(8, 40);
    run_rand(16, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
